// File: rtl/axi_write_initiator.sv
// Queues write commands and issues them one at a time as AXI AW/W/B transactions.
// Latency: AW/W valid one cycle after a command lands in an empty FIFO; one transaction in flight.
// Backpressure: cmd_ready drops while the FIFO is full; a stalled phase aborts after TIMEOUT_CYCLES.
module axi_write_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk_domain_a,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    axi_awvalid,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                    axi_awready,
  output logic                    axi_wvalid,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wready,
  input  logic                    axi_bvalid,
  input  logic [1:0]              axi_bresp,
  output logic                    axi_bready,
  output logic                    done_pulse,
  output logic                    err_pulse,
  output logic                    busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_WIDTH-1:0] TMR_MAX = TMR_WIDTH'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

  cmd_t                 fifo_mem [FIFO_DEPTH];
  cmd_t                 head;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 push, pop, empty, full;

  state_t               state, state_nxt;
  logic [TMR_WIDTH-1:0] tmr, tmr_nxt, tmr_inc;
  logic                 tmr_hit, aw_fin, w_fin;
  logic                 awvalid_nxt, wvalid_nxt, bready_nxt, done_nxt, err_nxt;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_WIDTH'(FIFO_DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // Command storage; no reset needed because count gates every read.
  always_ff @(posedge clk_domain_a) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_addr, cmd_data, cmd_strb};
  end

  // FIFO pointers and occupancy; a push and pop on the same edge cancel out.
  always_ff @(posedge clk_domain_a or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_WIDTH'(1);
      else if (!push && pop) count <= count - CNT_WIDTH'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_domain_a or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake tracking and phase timeout.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    awvalid_nxt = axi_awvalid;
    wvalid_nxt  = axi_wvalid;
    bready_nxt  = axi_bready;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    pop         = 1'b0;
    // A channel is finished once its valid has dropped or is handshaking now.
    aw_fin      = !axi_awvalid || axi_awready;
    w_fin       = !axi_wvalid || axi_wready;
    tmr_inc     = (tmr == TMR_MAX) ? tmr : tmr + TMR_WIDTH'(1);
    tmr_hit     = (tmr_inc == TMR_MAX);
    case (state)
      IDLE: begin
        tmr_nxt = '0;
        if (!empty) begin
          pop         = 1'b1;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
          state_nxt   = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        tmr_nxt     = tmr_inc;
        awvalid_nxt = !aw_fin;
        wvalid_nxt  = !w_fin;
        if (aw_fin && w_fin) begin
          bready_nxt = 1'b1;
          tmr_nxt    = '0;
          state_nxt  = RESP;
        end else if (tmr_hit) begin
          awvalid_nxt = 1'b0;
          wvalid_nxt  = 1'b0;
          err_nxt     = 1'b1;
          tmr_nxt     = '0;
          state_nxt   = IDLE;
        end
      end
      RESP: begin
        tmr_nxt = tmr_inc;
        if (axi_bvalid) begin
          bready_nxt = 1'b0;
          done_nxt   = (axi_bresp == 2'b00);
          err_nxt    = (axi_bresp != 2'b00);
          tmr_nxt    = '0;
          state_nxt  = IDLE;
        end else if (tmr_hit) begin
          bready_nxt = 1'b0;
          err_nxt    = 1'b1;
          tmr_nxt    = '0;
          state_nxt  = IDLE;
        end
      end
      default: begin
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        bready_nxt  = 1'b0;
        tmr_nxt     = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // Registered AXI outputs, status pulses, timer and payload captured on pop.
  always_ff @(posedge clk_domain_a or negedge rst_n) begin
    if (!rst_n) begin
      tmr         <= '0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_awaddr  <= '0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      done_pulse  <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      tmr         <= tmr_nxt;
      axi_awvalid <= awvalid_nxt;
      axi_wvalid  <= wvalid_nxt;
      axi_bready  <= bready_nxt;
      done_pulse  <= done_nxt;
      err_pulse   <= err_nxt;
      if (pop) begin
        axi_awaddr <= head.addr;
        axi_wdata  <= head.data;
        axi_wstrb  <= head.strb;
      end
    end
  end

endmodule

// File: tb/tb_axi_write_initiator.sv
// Bench for axi_write_initiator: table of single transactions against a delay-driven slave.
// Hand sequences cover timeout with a queued follower, FIFO full, and reset during RESP.
module tb_axi_write_initiator;

  logic        clk_domain_a = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic        axi_awvalid, axi_awready;
  logic [15:0] axi_awaddr;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic        done_pulse, err_pulse, busy;

  axi_write_initiator #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk_domain_a(clk_domain_a), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .done_pulse(done_pulse), .err_pulse(err_pulse), .busy(busy)
  );

  always #5 clk_domain_a = ~clk_domain_a;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d;
    logic [1:0]  bresp;
    int          e_aw, e_w, e_brise, e_bcyc, e_pulse, e_done, e_err;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int errors = 0;

  // Slave behaviour: each ready rises once its valid has been high for more than *_delay cycles.
  int aw_delay, w_delay, b_delay;
  // Monitor state, cleared per scenario.
  int cyc, aw_hi, w_hi, b_hi, aw_cnt, w_cnt, b_cnt, brise, first_aw, pulse_cyc;
  int done_cnt, err_cnt, both_cnt, pay_err;
  logic [15:0] aw_hold;
  logic [35:0] w_hold;
  logic [15:0] aw_q [$];
  logic [35:0] w_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    cyc = 0; aw_hi = 0; w_hi = 0; b_hi = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    brise = 0; first_aw = 0; pulse_cyc = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
    pay_err = 0; aw_q.delete(); w_q.delete();
  endtask

  // One clock: sample after the edge, record observations, then drive the slave side.
  task automatic step();
    @(posedge clk_domain_a);
    #1;
    cyc++;
    if (axi_awvalid) begin
      aw_hi++; aw_cnt++;
      if (aw_hi == 1) begin
        aw_hold = axi_awaddr;
        aw_q.push_back(axi_awaddr);
        if (first_aw == 0) first_aw = cyc;
      end else if (axi_awaddr !== aw_hold) pay_err++;
    end else aw_hi = 0;
    if (axi_wvalid) begin
      w_hi++; w_cnt++;
      if (w_hi == 1) begin
        w_hold = {axi_wdata, axi_wstrb};
        w_q.push_back({axi_wdata, axi_wstrb});
      end else if ({axi_wdata, axi_wstrb} !== w_hold) pay_err++;
    end else w_hi = 0;
    if (axi_bready) begin
      b_hi++; b_cnt++;
      if (brise == 0) brise = cyc;
    end else b_hi = 0;
    if (done_pulse) done_cnt++;
    if (err_pulse) err_cnt++;
    if (done_pulse && err_pulse) both_cnt++;
    if ((done_pulse || err_pulse) && pulse_cyc == 0) pulse_cyc = cyc;
    axi_awready = axi_awvalid && (aw_hi > aw_delay);
    axi_wready  = axi_wvalid && (w_hi > w_delay);
    axi_bvalid  = axi_bready && (b_hi > b_delay);
  endtask

  // Offer one command; it is accepted at the next edge where cmd_ready is high.
  task automatic push_cmd(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output bit ok);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s; ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int n_ok;
    logic [15:0] exp_addr [5];
    logic [31:0] exp_data [5];

    // addr, data, strb, aw_d, w_d, b_d, bresp | aw_cyc, w_cyc, bready_rise, bready_cyc, pulse_cyc, done, err
    vecs[0] = '{16'h1234, 32'hDEADBEEF, 4'hF, 0, 0, 1, 2'b00, 1, 1, 2, 2, 4, 1, 0};
    vecs[1] = '{16'h0100, 32'h11223344, 4'h3, 3, 0, 0, 2'b00, 4, 1, 5, 1, 6, 1, 0};
    vecs[2] = '{16'hA5A4, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b10, 1, 1, 2, 1, 3, 0, 1};
    vecs[3] = '{16'h0008, 32'h00000001, 4'h1, 0, 2, 0, 2'b00, 1, 3, 4, 1, 5, 1, 0};
    vecs[4] = '{16'hFFFC, 32'hFFFFFFFF, 4'hC, 2, 2, 2, 2'b01, 3, 3, 4, 3, 7, 0, 1};
    vecs[5] = '{16'h4000, 32'h5A5A5A5A, 4'h5, 1, 1, 0, 2'b11, 2, 2, 3, 1, 4, 0, 1};
    vecs[6] = '{16'h2222, 32'h87654321, 4'hF, 0, 0, 1000, 2'b00, 1, 1, 2, 15, 17, 0, 1};
    vecs[7] = '{16'h3333, 32'h0BADCAFE, 4'hF, 1000, 0, 0, 2'b00, 15, 1, 0, 0, 16, 0, 1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    aw_delay = 0; w_delay = 0; b_delay = 0;
    clr_mon();

    // Reset values.
    #12;
    chk("reset ctrl", 64'({axi_awvalid, axi_wvalid, axi_bready, done_pulse, err_pulse, busy, cmd_ready}), 64'h01);
    chk("reset payload", 64'({axi_awaddr, axi_wdata, axi_wstrb}), 64'h0);
    rst_n = 1'b1;
    step();
    chk("post-reset idle", 64'({axi_awvalid, axi_wvalid, axi_bready, busy, cmd_ready}), 64'h01);

    // Table of single transactions.
    for (int r = 0; r < 8; r++) begin
      aw_delay = vecs[r].aw_d; w_delay = vecs[r].w_d; b_delay = vecs[r].b_d;
      axi_bresp = vecs[r].bresp;
      push_cmd(vecs[r].addr, vecs[r].data, vecs[r].strb, ok);
      chk($sformatf("r%0d accepted", r), 64'(ok), 64'h1);
      clr_mon();
      repeat (30) step();
      chk($sformatf("r%0d aw_first", r), 64'(first_aw), 64'd1);
      chk($sformatf("r%0d aw_cycles", r), 64'(aw_cnt), 64'(vecs[r].e_aw));
      chk($sformatf("r%0d w_cycles", r), 64'(w_cnt), 64'(vecs[r].e_w));
      chk($sformatf("r%0d bready_rise", r), 64'(brise), 64'(vecs[r].e_brise));
      chk($sformatf("r%0d bready_cycles", r), 64'(b_cnt), 64'(vecs[r].e_bcyc));
      chk($sformatf("r%0d pulse_cycle", r), 64'(pulse_cyc), 64'(vecs[r].e_pulse));
      chk($sformatf("r%0d done_count", r), 64'(done_cnt), 64'(vecs[r].e_done));
      chk($sformatf("r%0d err_count", r), 64'(err_cnt), 64'(vecs[r].e_err));
      chk($sformatf("r%0d both_pulses", r), 64'(both_cnt), 64'd0);
      chk($sformatf("r%0d payload_stable", r), 64'(pay_err), 64'd0);
      chk($sformatf("r%0d aw_issues", r), 64'(aw_q.size()), 64'd1);
      if (aw_q.size() > 0)
        chk($sformatf("r%0d awaddr", r), 64'(aw_q[0]), 64'(vecs[r].addr));
      if (w_q.size() > 0)
        chk($sformatf("r%0d wdata_wstrb", r), 64'(w_q[0]), 64'({vecs[r].data, vecs[r].strb}));
      chk($sformatf("r%0d busy_end", r), 64'(busy), 64'd0);
    end

    // Timeout on AW with a second command queued behind it.
    aw_delay = 1000; w_delay = 0; b_delay = 0; axi_bresp = 2'b00;
    clr_mon();
    push_cmd(16'h0A00, 32'hAAAA0000, 4'hF, ok);
    push_cmd(16'h0B00, 32'hBBBB0000, 4'hF, ok);
    for (int i = 0; i < 40 && pulse_cyc == 0; i++) step();
    chk("to pulse_after_entry", 64'(pulse_cyc - first_aw), 64'd15);
    chk("to err_pulse", 64'(err_pulse), 64'h1);
    chk("to valids_cleared", 64'({axi_awvalid, axi_wvalid}), 64'h0);
    aw_delay = 0;
    repeat (20) step();
    chk("to issues", 64'(aw_q.size()), 64'd2);
    if (aw_q.size() == 2)
      chk("to order", 64'({aw_q[0], aw_q[1]}), 64'h0A000B00);
    chk("to done_count", 64'(done_cnt), 64'd1);
    chk("to err_count", 64'(err_cnt), 64'd1);
    chk("to busy_end", 64'(busy), 64'd0);

    // FIFO full: five back-to-back pushes with AW stalled, then a refused sixth.
    aw_delay = 1000; w_delay = 0; b_delay = 0;
    clr_mon();
    n_ok = 0;
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = 16'h1000 + 16'(i * 16);
      exp_data[i] = 32'hC0DE0000 + 32'(i);
      push_cmd(exp_addr[i], exp_data[i], 4'hF, ok);
      if (ok) n_ok++;
    end
    chk("full accepted", 64'(n_ok), 64'd5);
    chk("full cmd_ready", 64'(cmd_ready), 64'h0);
    cmd_valid = 1'b1; cmd_addr = 16'hBAD0; cmd_data = 32'hBAD0BAD0; cmd_strb = 4'hF;
    repeat (3) step();
    chk("full held", 64'({cmd_ready, busy}), 64'h1);
    cmd_valid = 1'b0;
    aw_delay = 0;
    repeat (60) step();
    chk("full issues", 64'(aw_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < aw_q.size() && i < w_q.size(); i++) begin
      chk($sformatf("full addr%0d", i), 64'(aw_q[i]), 64'(exp_addr[i]));
      chk($sformatf("full data%0d", i), 64'(w_q[i]), 64'({exp_data[i], 4'hF}));
    end
    chk("full done_count", 64'(done_cnt), 64'd5);
    chk("full err_count", 64'(err_cnt), 64'd0);
    chk("full payload_stable", 64'(pay_err), 64'd0);
    chk("full busy_end", 64'(busy), 64'd0);

    // Reset while waiting in RESP with a second command queued.
    aw_delay = 0; w_delay = 0; b_delay = 1000;
    clr_mon();
    push_cmd(16'h7000, 32'h70707070, 4'hF, ok);
    push_cmd(16'h7100, 32'h71717171, 4'hF, ok);
    for (int i = 0; i < 20 && !axi_bready; i++) step();
    chk("rst reached_resp", 64'(axi_bready), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst ctrl", 64'({axi_awvalid, axi_wvalid, axi_bready, done_pulse, err_pulse, busy, cmd_ready}), 64'h01);
    chk("rst payload", 64'({axi_awaddr, axi_wdata, axi_wstrb}), 64'h0);
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    #2;
    rst_n = 1'b1;
    clr_mon();
    b_delay = 0;
    repeat (25) step();
    chk("rst no_pulses", 64'(done_cnt + err_cnt), 64'd0);
    chk("rst fifo_flushed", 64'(aw_cnt), 64'd0);
    chk("rst busy_end", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
